mem_port_arbiter: RTL and testbench

Shares a single unified memory port between the instruction-fetch stage and the MEM stage of the RV32I 5-stage pipeline. It arbitrates and latches each access, runs a variable-latency valid/ready transaction on the memory side, and returns read data with a one-cycle ack pulse. It also drives the stall signals the pipeline uses to freeze IF and MEM while their access is pending.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_perf_cnt.sv | 28 ++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified memory-port arbiter: FSM states and requester IDs.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_e;

  localparam int unsigned PERF_CNT_W = 32;

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Grant and stall-cycle counters for the memory-port arbiter (built only with ARB_PERF_CNT_EN).
module mem_arb_perf_cnt
  import mem_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_grant,
  input  logic                  dm_grant,
  input  logic                  stall,
  output logic [PERF_CNT_W-1:0] perf_if_grants,
  output logic [PERF_CNT_W-1:0] perf_dm_grants,
  output logic [PERF_CNT_W-1:0] perf_stall_cycles
);

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_if_grants    <= '0;
      perf_dm_grants    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (if_grant) perf_if_grants    <= perf_if_grants + PERF_CNT_W'(1);
      if (dm_grant) perf_dm_grants    <= perf_dm_grants + PERF_CNT_W'(1);
      if (stall)    perf_stall_cycles <= perf_stall_cycles + PERF_CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MEM accesses onto one valid/ready memory port and drives pipeline stalls.
// Optional perf counters are built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                stall_if,
  output logic                stall_mem
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_if_grants,
  output logic [PERF_CNT_W-1:0] perf_dm_grants,
  output logic [PERF_CNT_W-1:0] perf_stall_cycles
`endif
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  function automatic logic [STREAK_W-1:0] streak_sat_inc(input logic [STREAK_W-1:0] v);
    return (v == STREAK_MAX) ? v : v + STREAK_W'(1);
  endfunction

  arb_state_e            state_q, state_d;
  logic [STREAK_W-1:0]   streak_q;
  logic                  if_ack_q, dm_ack_q;
  logic                  if_live, dm_live;
  logic                  grant_if, grant_dm;
  req_id_e               gnt_id;
  logic                  done;

  // A requester is invisible in its own ack cycle so a held req is not re-issued.
  assign if_live = if_req & ~if_ack_q;
  assign dm_live = dm_req & ~dm_ack_q;
  assign done    = (state_q != IDLE) & mem_ready;

  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    gnt_id   = REQ_IF;
    case (state_q)
      IDLE: begin
        if (dm_live && (!if_live || streak_q != STREAK_MAX)) begin
          grant_dm = 1'b1;
          gnt_id   = REQ_DM;
          state_d  = D_BUSY;
        end else if (if_live) begin
          grant_if = 1'b1;
          state_d  = I_BUSY;
        end
      end
      I_BUSY, D_BUSY: if (mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control: state, streak, ack pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      if_ack_q <= done & (state_q == I_BUSY);
      dm_ack_q <= done & (state_q == D_BUSY);
      if (grant_if)
        streak_q <= '0;
      else if (grant_dm && if_req)
        streak_q <= streak_sat_inc(streak_q);
    end
  end

  // Payload latched at grant, read data captured on completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if (grant_if || grant_dm) begin
        mem_addr  <= (gnt_id == REQ_DM) ? dm_addr : if_addr;
        mem_we    <= (gnt_id == REQ_DM) & dm_we;
        mem_wdata <= (gnt_id == REQ_DM) ? dm_wdata : '0;
        mem_wstrb <= (gnt_id == REQ_DM) ? dm_wstrb : STRB_W'(0);
      end
      if (done && state_q == I_BUSY)
        if_rdata <= mem_rdata;
      if (done && state_q == D_BUSY && !mem_we)
        dm_rdata <= mem_rdata;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign stall_if  = if_req & ~if_ack_q;
  assign stall_mem = dm_req & ~dm_ack_q;

`ifdef ARB_PERF_CNT_EN
  mem_arb_perf_cnt u_perf_cnt (
    .clk               (clk),
    .rst               (rst),
    .if_grant          (grant_if),
    .dm_grant          (grant_dm),
    .stall             (stall_if | stall_mem),
    .perf_if_grants    (perf_if_grants),
    .perf_dm_grants    (perf_dm_grants),
    .perf_stall_cycles (perf_stall_cycles)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (perf checks built with ARB_PERF_CNT_EN).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ack;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_wstrb;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        stall_if, stall_mem;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_grants, perf_dm_grants, perf_stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_wstrb  (dm_wstrb),
    .dm_rdata  (dm_rdata),
    .dm_ack    (dm_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_if_grants    (perf_if_grants),
    .perf_dm_grants    (perf_dm_grants),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One isolated access with mem_ready held high; entered and left on a negedge.
  task automatic access(input bit dm, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [31:0] rd);
    if (dm) begin
      dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata; dm_wstrb = strb;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    mem_ready = 1'b1;
    mem_rdata = rd;
    #1;
    chk("acc_c0_mem_req", mem_req, 0);
    chk("acc_c0_stall", dm ? stall_mem : stall_if, 1);
    @(negedge clk); #1;
    chk("acc_c1_mem_req", mem_req, 1);
    chk("acc_c1_addr", mem_addr, addr);
    chk("acc_c1_we", mem_we, dm ? we : 1'b0);
    chk("acc_c1_wstrb", mem_wstrb, dm ? strb : 4'h0);
    chk("acc_c1_stall", dm ? stall_mem : stall_if, 1);
    @(negedge clk); #1;
    chk("acc_c2_ack", dm ? dm_ack : if_ack, 1);
    chk("acc_c2_other_ack", dm ? if_ack : dm_ack, 0);
    chk("acc_c2_stall", dm ? stall_mem : stall_if, 0);
    if (!dm) chk("acc_c2_if_rdata", if_rdata, rd);
    else if (!we) chk("acc_c2_dm_rdata", dm_rdata, rd);
    if_req = 1'b0;
    dm_req = 1'b0;
    @(negedge clk); #1;
    chk("acc_c3_ack", dm ? dm_ack : if_ack, 0);
    chk("acc_c3_mem_req", mem_req, 0);
  endtask

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0;

    // Reset values
    @(negedge clk);
    if_req = 1'b1;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_dm_ack", dm_ack, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_stall_if_formula", stall_if, 1);
    chk("rst_stall_mem", stall_mem, 0);
    if_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Fetch only
    access(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0050_0093);

    // Simultaneous fetch + data read: data first, fetch issued in the dm_ack cycle
    if_req = 1'b1; if_addr = 32'h14;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    mem_ready = 1'b1; mem_rdata = 32'hAAAA_0001;
    #1;
    chk("both_c0_stall_if", stall_if, 1);
    chk("both_c0_stall_mem", stall_mem, 1);
    @(negedge clk); #1;
    chk("both_c1_mem_req", mem_req, 1);
    chk("both_c1_addr_dm", mem_addr, 32'h100);
    @(negedge clk); #1;
    chk("both_c2_dm_ack", dm_ack, 1);
    chk("both_c2_dm_rdata", dm_rdata, 32'hAAAA_0001);
    chk("both_c2_stall_if", stall_if, 1);
    dm_req = 1'b0;
    mem_rdata = 32'hBBBB_0002;
    @(negedge clk); #1;
    chk("both_c3_dm_ack", dm_ack, 0);
    chk("both_c3_mem_req", mem_req, 1);
    chk("both_c3_addr_if", mem_addr, 32'h14);
    chk("both_c3_if_ack", if_ack, 0);
    @(negedge clk); #1;
    chk("both_c4_if_ack", if_ack, 1);
    chk("both_c4_if_rdata", if_rdata, 32'hBBBB_0002);
    chk("both_c4_dm_rdata_hold", dm_rdata, 32'hAAAA_0001);
    if_req = 1'b0;
    @(negedge clk);

    // Streak: four contested data grants, then fetch wins
    mem_rdata = 32'h3333_0000;
    dm_req = 1'b1; dm_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if_req = 1'b1; if_addr = 32'h20; dm_addr = 32'h300 + 32'(k * 4);
      @(negedge clk); #1;
      chk("streak_dm_wins", mem_addr, 32'h300 + 32'(k * 4));
      @(negedge clk); #1;
      chk("streak_dm_ack", dm_ack, 1);
      if_req = 1'b0;
      @(negedge clk);
    end
    if_req = 1'b1; dm_addr = 32'h310;
    @(negedge clk); #1;
    chk("streak_if_forced_addr", mem_addr, 32'h20);
    chk("streak_if_forced_we", mem_we, 0);
    @(negedge clk); #1;
    chk("streak_if_ack", if_ack, 1);
    chk("streak_dm_stall_held", stall_mem, 1);
    if_req = 1'b0;
    @(negedge clk); #1;
    chk("streak_restart_dm_addr", mem_addr, 32'h310);
    @(negedge clk); #1;
    chk("streak_restart_dm_ack", dm_ack, 1);
    dm_req = 1'b0;
    @(negedge clk);

    // Write with three wait cycles
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'hF;
    mem_ready = 1'b0; mem_rdata = 32'h9999_9999;
    #1;
    chk("wr_c0_mem_req", mem_req, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 4) mem_ready = 1'b1;
      #1;
      chk("wr_busy_mem_req", mem_req, 1);
      chk("wr_busy_addr", mem_addr, 32'h200);
      chk("wr_busy_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("wr_busy_we", mem_we, 1);
      chk("wr_busy_wstrb", mem_wstrb, 4'hF);
      chk("wr_busy_dm_ack", dm_ack, 0);
      chk("wr_busy_stall_mem", stall_mem, 1);
    end
    @(negedge clk); #1;
    chk("wr_dm_ack", dm_ack, 1);
    chk("wr_dm_rdata_unchanged", dm_rdata, 32'h3333_0000);
    chk("wr_stall_mem_ack", stall_mem, 0);
    dm_req = 1'b0;
    @(negedge clk); #1;
    chk("wr_after_ack", dm_ack, 0);
    chk("wr_after_mem_req", mem_req, 0);

    // Reset while D_BUSY with mem_ready low
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400; mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("rstmid_busy", mem_req, 1);
    rst = 1'b0;
    dm_req = 1'b0;
    #1;
    chk("rstmid_mem_req_drop", mem_req, 0);
    chk("rstmid_mem_addr", mem_addr, 0);
    chk("rstmid_if_rdata", if_rdata, 0);
    chk("rstmid_dm_rdata", dm_rdata, 0);
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("rstmid_no_ack0", dm_ack, 0);
    @(negedge clk); #1;
    chk("rstmid_no_ack1", dm_ack, 0);
    chk("rstmid_idle", mem_req, 0);

    // Three fetches and two data accesses from a fresh reset
    access(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h0000_0077);
    access(1'b1, 1'b0, 32'h44, 32'h0, 4'h0, 32'h1234_5678);
    access(1'b0, 1'b0, 32'h48, 32'h0, 4'h0, 32'h0000_000A);
    access(1'b1, 1'b1, 32'h4C, 32'hCAFE_F00D, 4'h3, 32'h5555_5555);
    chk("post_wr_dm_rdata", dm_rdata, 32'h1234_5678);
    access(1'b0, 1'b0, 32'h50, 32'h0, 4'h0, 32'h0000_00BB);
`ifdef ARB_PERF_CNT_EN
    chk("perf_if_grants", perf_if_grants, 3);
    chk("perf_dm_grants", perf_dm_grants, 2);
    chk("perf_stall_cycles", perf_stall_cycles, 10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
